// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI requester arbiter.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    XFER   = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Word width of the attached spi master's din.
  localparam int DATA_W_DEF = 12;

  // rr_pick works on a fixed 8-bit request vector; callers zero-extend.
  localparam int MAX_REQ = 8;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } pick_t;

  // Round-robin pick: first set bit at or above ptr, wrapping at n_req.
  // The loop runs from the farthest offset down to offset 0, so the
  // nearest set bit is the last one written and therefore wins.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [2:0]         ptr,
                                    input int                 n_req);
    pick_t p;
    int    c;
    p = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n_req) begin
        c = int'(ptr) + k;
        if (c >= n_req) c = c - n_req;
        if (req[c[2:0]]) begin
          p.vld = 1'b1;
          p.idx = c[2:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/spi_req_arbiter_if.sv
// Bundle of requester-side and spi-side signals of the arbiter.
// Latency: n/a (wires only).
// Backpressure: req is held until done/err; newd is held until cs falls.
//   slave  : arbiter view (takes req/req_data/cs, drives gnt/done/err/newd/din)
//   master : client + spi view (the opposite directions)
interface spi_req_arbiter_if
  import spi_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DATA_W_DEF
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        done;
  logic [N_REQ-1:0]        err;
  logic                    newd;
  logic [DATA_W-1:0]       din;
  logic                    cs;

  modport slave (
    input  req, req_data, cs,
    output gnt, done, err, newd, din
  );

  modport master (
    output req, req_data, cs,
    input  gnt, done, err, newd, din
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: lowest set req at or above ptr, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; vld=0 when no request is set.
//   req : request vector      ptr : search start index
//   vld : some request set    idx : winning index
module rr_picker
  import spi_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic             vld,
  output logic [PTR_W-1:0] idx
);
  pick_t p;

  always_comb begin
    p   = rr_pick(MAX_REQ'(req), 3'(ptr), N_REQ);
    vld = p.vld;
    idx = PTR_W'(p.idx);
  end
endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one spi master among N_REQ clients.
// Latency: req seen in IDLE -> gnt/newd/din registered on that edge; done/err one cycle after cs rises / timeout.
// Backpressure: clients hold req until done/err; newd held until cs falls or START_TO cycles elapse.
//   clk, rst : clock, synchronous active-high reset
//   bus      : req/req_data/gnt/done/err to clients, newd/din/cs to the spi master
//   busy     : high whenever the sequencer is not in IDLE
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int START_TO = 64
) (
  input  logic                clk,
  input  logic                rst,
  spi_req_arbiter_if.slave    bus,
  output logic                busy
);
  localparam int              PTR_W    = $clog2(N_REQ);
  localparam int              CNT_W    = $clog2(START_TO) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TO - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    win_q, win_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic [N_REQ-1:0]    err_q, err_d;
  logic                newd_q, newd_d;
  logic [DATA_W-1:0]   din_q, din_d;

  logic                pick_vld;
  logic [PTR_W-1:0]    pick_idx;

  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req (bus.req),
    .ptr (rr_ptr_q),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    err_d    = '0;
    newd_d   = newd_q;
    din_d    = din_q;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          win_d   = pick_idx;
          din_d   = bus.req_data[pick_idx*DATA_W +: DATA_W];
          gnt_d   = N_REQ'(1) << pick_idx;
          newd_d  = 1'b1;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        // cs falling is checked first so a start on the last allowed
        // cycle is still treated as a successful start.
        if (!bus.cs) begin
          newd_d  = 1'b0;
          state_d = XFER;
        end else if (cnt_q == CNT_LAST) begin
          newd_d  = 1'b0;
          err_d   = gnt_q;
          gnt_d   = '0;
          state_d = FINISH;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
      end

      XFER: begin
        if (bus.cs) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          state_d = FINISH;
        end
      end

      FINISH: begin
        // The extra idle cycle lets cs be re-sampled high before the next newd.
        rr_ptr_d = (win_q == PTR_LAST) ? '0 : win_q + 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      newd_q   <= 1'b0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      newd_q   <= newd_d;
      din_q    <= din_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.newd = newd_q;
  assign bus.din  = din_q;
  assign busy     = (state_q != IDLE);
endmodule
